// File: rtl/pulp_cluster_hwpe_arb_pkg.sv
// pulp_cluster_hwpe_arb_pkg: shared defaults, payload types and helpers for the HWPE TCDM arbiter.
package pulp_cluster_hwpe_arb_pkg;
  localparam int N_HWPE_DEF = 2;
  localparam int N_HWPE_PORTS_DEF = 2;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam bit HWPE_PRESENT = 1'b1;
  // Wide enough for up to 8 HWPEs.
  typedef logic [2:0] hwpe_id_t;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]   add;
    logic                    wen;
    logic [DATA_W_DEF/8-1:0] be;
    logic [DATA_W_DEF-1:0]   data;
  } hwpe_tcdm_req_t;
  typedef struct packed {
    logic                  r_valid;
    logic [DATA_W_DEF-1:0] r_data;
  } hwpe_tcdm_resp_t;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/pulp_cluster_hwpe_rr_lane.sv
// pulp_cluster_hwpe_rr_lane: one TCDM lane shared by N_HWPE requesters, round-robin with
// request locking until handshake and single-cycle response routing.
module pulp_cluster_hwpe_rr_lane
  import pulp_cluster_hwpe_arb_pkg::*;
#(
  parameter int N_HWPE = 2,
  parameter int PW     = 69,
  parameter int DATA_W = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_HWPE-1:0]              en_i,
  input  logic [N_HWPE-1:0]              req_i,
  input  logic [N_HWPE-1:0][PW-1:0]      pay_i,
  output logic [N_HWPE-1:0]              gnt_o,
  output logic [N_HWPE-1:0]              r_valid_o,
  output logic [N_HWPE-1:0][DATA_W-1:0]  r_data_o,
  output logic                           req_o,
  output logic [PW-1:0]                  pay_o,
  input  logic                           gnt_i,
  input  logic                           r_valid_i,
  input  logic [DATA_W-1:0]              r_data_i
);
  logic [N_HWPE-1:0] elig;
  hwpe_id_t rr_q, lock_id_q, resp_id_q, win;
  logic lock_q, resp_pend_q, vld, hs;
  always_comb begin
    elig = req_i & en_i;
    win = lock_q ? lock_id_q : '0;
    vld = 1'b0;
    // Descending scans: the last hit is the lowest eligible id, then the lowest at or above rr_q.
    for (int h = N_HWPE - 1; h >= 0; h--) begin
      if (!lock_q && elig[h]) begin
        win = hwpe_id_t'(h);
        vld = 1'b1;
      end
    end
    for (int h = N_HWPE - 1; h >= 0; h--)
      if (!lock_q && elig[h] && hwpe_id_t'(h) >= rr_q) win = hwpe_id_t'(h);
    for (int h = 0; h < N_HWPE; h++)
      if (lock_q && hwpe_id_t'(h) == lock_id_q) vld = elig[h];
    vld = vld & rst_ni;
    req_o = vld;
    hs = vld & gnt_i;
    pay_o = '0;
    gnt_o = '0;
    r_valid_o = '0;
    r_data_o = '0;
    for (int h = 0; h < N_HWPE; h++) begin
      if (vld && win == hwpe_id_t'(h)) begin
        pay_o = pay_i[h];
        gnt_o[h] = gnt_i;
      end
      if (resp_pend_q && resp_id_q == hwpe_id_t'(h)) begin
        r_valid_o[h] = r_valid_i;
        r_data_o[h] = r_data_i;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rr_q <= '0;
      lock_q <= 1'b0;
      lock_id_q <= '0;
      resp_id_q <= '0;
      resp_pend_q <= 1'b0;
    end else begin
      lock_q <= vld & ~gnt_i;
      if (vld & ~gnt_i) lock_id_q <= win;
      if (hs) begin
        rr_q <= (win == hwpe_id_t'(N_HWPE - 1)) ? '0 : win + hwpe_id_t'(1);
        resp_id_q <= win;
      end
      resp_pend_q <= hs;
    end
endmodule

// File: rtl/pulp_cluster_hwpe_tcdm_arb.sv
// pulp_cluster_hwpe_tcdm_arb: shares N_HWPE_PORTS TCDM lanes among N_HWPE HWPEs, one rr lane each.
// Define PULP_HWPE_ARB_STATS_EN to add saturating grant/stall counters.
module pulp_cluster_hwpe_tcdm_arb
  import pulp_cluster_hwpe_arb_pkg::*;
#(
  parameter int N_HWPE       = N_HWPE_DEF,
  parameter int N_HWPE_PORTS = N_HWPE_PORTS_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
`ifdef PULP_HWPE_ARB_STATS_EN
  input  logic                                      stat_clr_i,
  output logic [N_HWPE*32-1:0]                      stat_gnt_o,
  output logic [31:0]                               stat_stall_o,
`endif
  input  logic [N_HWPE-1:0]                         hwpe_en_i,
  input  logic [N_HWPE*N_HWPE_PORTS-1:0]            hwpe_req_i,
  input  logic [N_HWPE*N_HWPE_PORTS*ADDR_W-1:0]     hwpe_add_i,
  input  logic [N_HWPE*N_HWPE_PORTS-1:0]            hwpe_wen_i,
  input  logic [N_HWPE*N_HWPE_PORTS*DATA_W/8-1:0]   hwpe_be_i,
  input  logic [N_HWPE*N_HWPE_PORTS*DATA_W-1:0]     hwpe_data_i,
  output logic [N_HWPE*N_HWPE_PORTS-1:0]            hwpe_gnt_o,
  output logic [N_HWPE*N_HWPE_PORTS-1:0]            hwpe_r_valid_o,
  output logic [N_HWPE*N_HWPE_PORTS*DATA_W-1:0]     hwpe_r_data_o,
  output logic [N_HWPE_PORTS-1:0]                   tcdm_req_o,
  output logic [N_HWPE_PORTS*ADDR_W-1:0]            tcdm_add_o,
  output logic [N_HWPE_PORTS-1:0]                   tcdm_wen_o,
  output logic [N_HWPE_PORTS*DATA_W/8-1:0]          tcdm_be_o,
  output logic [N_HWPE_PORTS*DATA_W-1:0]            tcdm_data_o,
  input  logic [N_HWPE_PORTS-1:0]                   tcdm_gnt_i,
  input  logic [N_HWPE_PORTS-1:0]                   tcdm_r_valid_i,
  input  logic [N_HWPE_PORTS*DATA_W-1:0]            tcdm_r_data_i
);
  localparam int BW = DATA_W / 8;
  localparam int PW = ADDR_W + 1 + BW + DATA_W;
  genvar p, h;
  for (p = 0; p < N_HWPE_PORTS; p++) begin : g_lane
    logic [N_HWPE-1:0] req, gnt, rv;
    logic [N_HWPE-1:0][PW-1:0] pay;
    logic [N_HWPE-1:0][DATA_W-1:0] rd;
    logic [PW-1:0] lane_pay;
    // Flat HWPE vectors are HWPE-major: entry h*N_HWPE_PORTS+p is HWPE h on lane p.
    for (h = 0; h < N_HWPE; h++) begin : g_hwpe
      localparam int idx = h * N_HWPE_PORTS + p;
      assign req[h] = hwpe_req_i[idx];
      assign pay[h] = {hwpe_add_i[idx*ADDR_W+:ADDR_W], hwpe_wen_i[idx],
                       hwpe_be_i[idx*BW+:BW], hwpe_data_i[idx*DATA_W+:DATA_W]};
      assign hwpe_gnt_o[idx] = gnt[h];
      assign hwpe_r_valid_o[idx] = rv[h];
      assign hwpe_r_data_o[idx*DATA_W+:DATA_W] = rd[h];
    end
    pulp_cluster_hwpe_rr_lane #(.N_HWPE(N_HWPE), .PW(PW), .DATA_W(DATA_W)) u_lane (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(hwpe_en_i), .req_i(req), .pay_i(pay),
      .gnt_o(gnt), .r_valid_o(rv), .r_data_o(rd), .req_o(tcdm_req_o[p]), .pay_o(lane_pay),
      .gnt_i(tcdm_gnt_i[p]), .r_valid_i(tcdm_r_valid_i[p]), .r_data_i(tcdm_r_data_i[p*DATA_W+:DATA_W])
    );
    assign {tcdm_add_o[p*ADDR_W+:ADDR_W], tcdm_wen_o[p], tcdm_be_o[p*BW+:BW],
            tcdm_data_o[p*DATA_W+:DATA_W]} = lane_pay;
  end
`ifdef PULP_HWPE_ARB_STATS_EN
  logic [N_HWPE-1:0][31:0] gnt_cnt_q;
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      gnt_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (stat_clr_i) begin
      gnt_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_HWPE; i++)
        gnt_cnt_q[i] <= sat_add(gnt_cnt_q[i], 32'($countones(hwpe_gnt_o[i*N_HWPE_PORTS+:N_HWPE_PORTS])));
      stall_cnt_q <= sat_add(stall_cnt_q, 32'($countones(tcdm_req_o & ~tcdm_gnt_i)));
    end
  assign stat_gnt_o = gnt_cnt_q;
  assign stat_stall_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pulp_cluster_hwpe_tcdm_arb.sv
// tb_pulp_cluster_hwpe_tcdm_arb: directed plus random stimulus against a per-lane round-robin reference.
module tb_pulp_cluster_hwpe_tcdm_arb;
  localparam int N = 2, P = 2, AW = 32, DW = 32, BW = DW / 8;
  logic clk_i = 1'b0, rst_ni = 1'b1;
  logic [N-1:0] en;
  logic [N*P-1:0] req, wen, gnt, rv;
  logic [N*P*AW-1:0] add;
  logic [N*P*BW-1:0] be;
  logic [N*P*DW-1:0] data, rd;
  logic [P-1:0] treq, twen, tgnt, trv;
  logic [P*AW-1:0] tadd;
  logic [P*BW-1:0] tbe;
  logic [P*DW-1:0] tdata, trd;
`ifdef PULP_HWPE_ARB_STATS_EN
  logic sclr;
  logic [N*32-1:0] sgnt;
  logic [31:0] sstall;
  longint mg[N], ms;
`endif
  int checks = 0, errors = 0;
  int rr[P], lid[P], rid[P];
  bit lk[P], pend[P];

  always #5 clk_i = ~clk_i;

  pulp_cluster_hwpe_tcdm_arb #(.N_HWPE(N), .N_HWPE_PORTS(P), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
`ifdef PULP_HWPE_ARB_STATS_EN
    .stat_clr_i(sclr), .stat_gnt_o(sgnt), .stat_stall_o(sstall),
`endif
    .hwpe_en_i(en), .hwpe_req_i(req), .hwpe_add_i(add), .hwpe_wen_i(wen), .hwpe_be_i(be),
    .hwpe_data_i(data), .hwpe_gnt_o(gnt), .hwpe_r_valid_o(rv), .hwpe_r_data_o(rd),
    .tcdm_req_o(treq), .tcdm_add_o(tadd), .tcdm_wen_o(twen), .tcdm_be_o(tbe), .tcdm_data_o(tdata),
    .tcdm_gnt_i(tgnt), .tcdm_r_valid_i(trv), .tcdm_r_data_i(trd)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one cycle against the reference, then advances the reference across the clock edge.
  task automatic cycle();
    logic [P-1:0] e_treq, e_twen;
    logic [P*AW-1:0] e_tadd;
    logic [P*BW-1:0] e_tbe;
    logic [P*DW-1:0] e_tdata;
    logic [N*P-1:0] e_gnt, e_rv;
    logic [N*P*DW-1:0] e_rd;
    logic [N-1:0] el;
    int win[P];
    bit val[P];
    #1;
    if (!rst_ni) begin
      for (int p = 0; p < P; p++) begin rr[p] = 0; lk[p] = 0; lid[p] = 0; rid[p] = 0; pend[p] = 0; end
`ifdef PULP_HWPE_ARB_STATS_EN
      for (int h = 0; h < N; h++) mg[h] = 0;
      ms = 0;
`endif
    end
    e_treq = '0; e_twen = '0; e_tadd = '0; e_tbe = '0; e_tdata = '0; e_gnt = '0; e_rv = '0; e_rd = '0;
    for (int p = 0; p < P; p++) begin
      for (int h = 0; h < N; h++) el[h] = req[h*P+p] & en[h];
      val[p] = 0;
      win[p] = 0;
      if (lk[p]) begin
        win[p] = lid[p];
        val[p] = el[lid[p]];
      end else
        for (int i = N - 1; i >= 0; i--)
          if (el[(rr[p] + i) % N]) begin val[p] = 1; win[p] = (rr[p] + i) % N; end
      val[p] = val[p] && rst_ni;
      if (val[p]) begin
        e_treq[p] = 1'b1;
        e_tadd[p*AW+:AW] = add[(win[p]*P+p)*AW+:AW];
        e_twen[p] = wen[win[p]*P+p];
        e_tbe[p*BW+:BW] = be[(win[p]*P+p)*BW+:BW];
        e_tdata[p*DW+:DW] = data[(win[p]*P+p)*DW+:DW];
        e_gnt[win[p]*P+p] = tgnt[p];
      end
      if (pend[p]) begin
        e_rv[rid[p]*P+p] = trv[p];
        e_rd[(rid[p]*P+p)*DW+:DW] = trd[p*DW+:DW];
      end
    end
    chk("tcdm_req", treq, e_treq);
    chk("tcdm_add", tadd, e_tadd);
    chk("tcdm_wen", twen, e_twen);
    chk("tcdm_be", tbe, e_tbe);
    chk("tcdm_data", tdata, e_tdata);
    chk("hwpe_gnt", gnt, e_gnt);
    chk("hwpe_r_valid", rv, e_rv);
    chk("hwpe_r_data", rd, e_rd);
`ifdef PULP_HWPE_ARB_STATS_EN
    begin
      logic [N*32-1:0] e_sg;
      for (int h = 0; h < N; h++) e_sg[h*32+:32] = mg[h][31:0];
      chk("stat_gnt", sgnt, e_sg);
      chk("stat_stall", sstall, ms[31:0]);
    end
`endif
    @(posedge clk_i);
    if (rst_ni) begin
      for (int p = 0; p < P; p++) begin
        lk[p] = val[p] && !tgnt[p];
        if (lk[p]) lid[p] = win[p];
        pend[p] = val[p] && tgnt[p];
        if (pend[p]) begin rr[p] = (win[p] + 1) % N; rid[p] = win[p]; end
      end
`ifdef PULP_HWPE_ARB_STATS_EN
      if (sclr) begin
        for (int h = 0; h < N; h++) mg[h] = 0;
        ms = 0;
      end else
        for (int p = 0; p < P; p++) begin
          if (val[p] && tgnt[p] && mg[win[p]] < 64'hFFFF_FFFF) mg[win[p]]++;
          if (val[p] && !tgnt[p] && ms < 64'hFFFF_FFFF) ms++;
        end
`endif
    end
    @(negedge clk_i);
  endtask

  initial begin
    en = '1; req = '0; wen = '0; add = '0; be = '0; data = '0; tgnt = '0; trv = '0; trd = '0;
`ifdef PULP_HWPE_ARB_STATS_EN
    sclr = 1'b0;
`endif
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    req = '1; tgnt = '1; trv = '1; trd = '1; add = '1;
    cycle();
    cycle();
    rst_ni = 1'b1;
    req = '0; trv = '0; add = '0; trd = '0;
    // Single read with response one cycle later.
    req = 4'b0001; add[31:0] = 32'h1000; wen[0] = 1'b1; tgnt = 2'b11;
    #1 chk("plan_gnt_h0", gnt[0], 1'b1);
    cycle();
    req = '0; trv = 2'b01; trd[31:0] = 32'hCAFE;
    #1 chk("plan_rdata_h0", rd[31:0], 32'hCAFE);
    chk("plan_rdata_h1", rd[2*DW+:DW], 32'h0);
    cycle();
    // Round robin on lane 0.
    req = 4'b0101; tgnt = 2'b01; trv = 2'b01;
    for (int i = 0; i < 4; i++) begin
      trd = (P*DW)'({$urandom, $urandom});
      #1 chk("rr_one_winner", gnt[0] ^ gnt[2], 1'b1);
      cycle();
    end
    // Lock hold on lane 1.
    trv = '0; tgnt = '0; req = 4'b1000; add[3*AW+:AW] = 32'h2000; add[1*AW+:AW] = 32'h3000;
    cycle();
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("lock_add", tadd[AW+:AW], 32'h2000);
      cycle();
    end
    tgnt = 2'b10;
    #1 chk("lock_gnt_h1", gnt[3], 1'b1);
    cycle();
    #1 chk("after_lock_add", tadd[AW+:AW], 32'h3000);
    cycle();
    // Run-time mask.
    en = 2'b10; req = '1; tgnt = '1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mask_gnt_h0", gnt[1:0], 2'b00);
      cycle();
    end
    en = '1;
    // Reset right after a grant.
    req = 4'b0001; tgnt = 2'b01;
    cycle();
    rst_ni = 1'b0; trv = 2'b01;
    cycle();
    rst_ni = 1'b1; req = 4'b0101;
    #1 chk("post_rst_rv", rv, '0);
    chk("post_rst_rr", gnt[0], 1'b1);
    cycle();
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req = (N*P)'($urandom);
      en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      wen = (N*P)'($urandom);
      be = (N*P*BW)'($urandom);
      for (int j = 0; j < N * P; j++) begin add[j*AW+:AW] = $urandom; data[j*DW+:DW] = $urandom; end
      tgnt = P'($urandom);
      trv = P'($urandom);
      for (int j = 0; j < P; j++) trd[j*DW+:DW] = $urandom;
`ifdef PULP_HWPE_ARB_STATS_EN
      sclr = ($urandom_range(0, 15) == 0);
`endif
      cycle();
    end
`ifdef PULP_HWPE_ARB_STATS_EN
    en = '1; trv = '0; req = '0; sclr = 1'b1;
    cycle();
    sclr = 1'b0; req = 4'b0001; tgnt = 2'b01;
    for (int i = 0; i < 5; i++) cycle();
    req = 4'b1000; tgnt = 2'b00;
    for (int i = 0; i < 3; i++) cycle();
    #1 chk("stat_gnt_5", sgnt[31:0], 32'd5);
    chk("stat_stall_3", sstall, 32'd3);
    sclr = 1'b1;
    cycle();
    sclr = 1'b0; req = '0;
    #1 chk("stat_gnt_clr", sgnt, '0);
    chk("stat_stall_clr", sstall, '0);
    cycle();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
